// File: rtl/ddr_axi_arbiter_pkg.sv
// Shared definitions for the DDR AXI arbiter: address/data widths derived from
// the DDR geometry macros and the write/read FSM state encodings.
`ifndef DDR_BA_BITS
`define DDR_BA_BITS 3
`endif
`ifndef DDR_ROW_BITS
`define DDR_ROW_BITS 14
`endif
`ifndef DDR_COL_BITS
`define DDR_COL_BITS 10
`endif
`ifndef DDR_DQ_LEVEL
`define DDR_DQ_LEVEL 1
`endif

package ddr_axi_arbiter_pkg;
    localparam int BA_BITS  = `DDR_BA_BITS;
    localparam int ROW_BITS = `DDR_ROW_BITS;
    localparam int COL_BITS = `DDR_COL_BITS;
    localparam int DQ_LEVEL = `DDR_DQ_LEVEL;

    localparam int AW = BA_BITS + ROW_BITS + COL_BITS + DQ_LEVEL - 1;
    localparam int DW = 8 << DQ_LEVEL;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;
endpackage

// File: rtl/ddr_axi_arbiter_rr_pick.sv
// Two-way request picker. Round-robin by default (last = index served last);
// with DDR_AXI_ARB_FIXED_PRI_EN defined, master 0 always wins.
module ddr_axi_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
`ifdef DDR_AXI_ARB_FIXED_PRI_EN
    logic unused_last;
    assign unused_last = last;
    assign gnt = req[0] ? 2'b01 : (req[1] ? 2'b10 : 2'b00);
`else
    always_comb begin
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end
`endif
endmodule

// File: rtl/ddr_axi_arbiter.sv
// Two-master to one-slave AXI arbiter in front of the DDR controller; write and
// read channels are owned independently for one full transaction each.
// Build option: DDR_AXI_ARB_FIXED_PRI_EN selects fixed priority (master 0 first).
module ddr_axi_arbiter
    import ddr_axi_arbiter_pkg::*;
(
    input  logic          core_clk,
    input  logic          core_rst_sync,
    input  logic          m0_awvalid,
    output logic          m0_awready,
    input  logic [AW-1:0] m0_awaddr,
    input  logic [7:0]    m0_awlen,
    input  logic          m0_wvalid,
    output logic          m0_wready,
    input  logic          m0_wlast,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_bvalid,
    input  logic          m0_bready,
    input  logic          m0_arvalid,
    output logic          m0_arready,
    input  logic [AW-1:0] m0_araddr,
    input  logic [7:0]    m0_arlen,
    output logic          m0_rvalid,
    input  logic          m0_rready,
    output logic          m0_rlast,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_awvalid,
    output logic          m1_awready,
    input  logic [AW-1:0] m1_awaddr,
    input  logic [7:0]    m1_awlen,
    input  logic          m1_wvalid,
    output logic          m1_wready,
    input  logic          m1_wlast,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_bvalid,
    input  logic          m1_bready,
    input  logic          m1_arvalid,
    output logic          m1_arready,
    input  logic [AW-1:0] m1_araddr,
    input  logic [7:0]    m1_arlen,
    output logic          m1_rvalid,
    input  logic          m1_rready,
    output logic          m1_rlast,
    output logic [DW-1:0] m1_rdata,
    output logic          s_awvalid,
    input  logic          s_awready,
    output logic [AW-1:0] s_awaddr,
    output logic [7:0]    s_awlen,
    output logic          s_wvalid,
    input  logic          s_wready,
    output logic          s_wlast,
    output logic [DW-1:0] s_wdata,
    input  logic          s_bvalid,
    output logic          s_bready,
    output logic          s_arvalid,
    input  logic          s_arready,
    output logic [AW-1:0] s_araddr,
    output logic [7:0]    s_arlen,
    input  logic          s_rvalid,
    output logic          s_rready,
    input  logic          s_rlast,
    input  logic [DW-1:0] s_rdata,
    output logic [1:0]    wgrant,
    output logic [1:0]    rgrant
);
    logic [1:0]    m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready;
    logic [1:0]    m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_rlast;
    logic [AW-1:0] m_awaddr [2];
    logic [AW-1:0] m_araddr [2];
    logic [7:0]    m_awlen  [2];
    logic [7:0]    m_arlen  [2];
    logic [DW-1:0] m_wdata  [2];
    logic [DW-1:0] m_rdata  [2];

    assign m_awvalid = {m1_awvalid, m0_awvalid};
    assign m_wvalid  = {m1_wvalid,  m0_wvalid};
    assign m_wlast   = {m1_wlast,   m0_wlast};
    assign m_bready  = {m1_bready,  m0_bready};
    assign m_arvalid = {m1_arvalid, m0_arvalid};
    assign m_rready  = {m1_rready,  m0_rready};
    assign m_awaddr[0] = m0_awaddr;  assign m_awaddr[1] = m1_awaddr;
    assign m_araddr[0] = m0_araddr;  assign m_araddr[1] = m1_araddr;
    assign m_awlen[0]  = m0_awlen;   assign m_awlen[1]  = m1_awlen;
    assign m_arlen[0]  = m0_arlen;   assign m_arlen[1]  = m1_arlen;
    assign m_wdata[0]  = m0_wdata;   assign m_wdata[1]  = m1_wdata;

    assign {m1_awready, m0_awready} = m_awready;
    assign {m1_wready,  m0_wready}  = m_wready;
    assign {m1_bvalid,  m0_bvalid}  = m_bvalid;
    assign {m1_arready, m0_arready} = m_arready;
    assign {m1_rvalid,  m0_rvalid}  = m_rvalid;
    assign {m1_rlast,   m0_rlast}   = m_rlast;
    assign m0_rdata = m_rdata[0];
    assign m1_rdata = m_rdata[1];

    wstate_e    wstate_q, wstate_d;
    rstate_e    rstate_q, rstate_d;
    logic       wsel_q, wsel_d, rsel_q, rsel_d;
    logic [1:0] wgrant_q, wgrant_d, rgrant_q, rgrant_d;
    logic [1:0] wpick, rpick;
    logic       wlast_srv, rlast_srv;

`ifdef DDR_AXI_ARB_FIXED_PRI_EN
    assign wlast_srv = 1'b1;
    assign rlast_srv = 1'b1;
`else
    logic wlast_srv_q, wlast_srv_d, rlast_srv_q, rlast_srv_d;
    assign wlast_srv = wlast_srv_q;
    assign rlast_srv = rlast_srv_q;
`endif

    ddr_axi_rr_pick u_wpick (.req(m_awvalid), .last(wlast_srv), .gnt(wpick));
    ddr_axi_rr_pick u_rpick (.req(m_arvalid), .last(rlast_srv), .gnt(rpick));

    always_comb begin
        wstate_d = wstate_q;
        wsel_d   = wsel_q;
        wgrant_d = wgrant_q;
        rstate_d = rstate_q;
        rsel_d   = rsel_q;
        rgrant_d = rgrant_q;
`ifndef DDR_AXI_ARB_FIXED_PRI_EN
        wlast_srv_d = wlast_srv_q;
        rlast_srv_d = rlast_srv_q;
`endif
        case (wstate_q)
            W_IDLE: if (|m_awvalid) begin
                wstate_d = W_ADDR;
                wsel_d   = wpick[1];
                wgrant_d = wpick;
            end
            W_ADDR: if (s_awvalid && s_awready) wstate_d = W_DATA;
            W_DATA: if (s_wvalid && s_wready && s_wlast) wstate_d = W_RESP;
            W_RESP: if (s_bvalid && s_bready) begin
                wstate_d = W_IDLE;
                wgrant_d = 2'b00;
`ifndef DDR_AXI_ARB_FIXED_PRI_EN
                wlast_srv_d = wsel_q;
`endif
            end
            default: wstate_d = W_IDLE;
        endcase
        case (rstate_q)
            R_IDLE: if (|m_arvalid) begin
                rstate_d = R_ADDR;
                rsel_d   = rpick[1];
                rgrant_d = rpick;
            end
            R_ADDR: if (s_arvalid && s_arready) rstate_d = R_DATA;
            R_DATA: if (s_rvalid && s_rready && s_rlast) begin
                rstate_d = R_IDLE;
                rgrant_d = 2'b00;
`ifndef DDR_AXI_ARB_FIXED_PRI_EN
                rlast_srv_d = rsel_q;
`endif
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst_sync) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
            wsel_q   <= 1'b0;
            rsel_q   <= 1'b0;
            wgrant_q <= 2'b00;
            rgrant_q <= 2'b00;
`ifndef DDR_AXI_ARB_FIXED_PRI_EN
            wlast_srv_q <= 1'b1;
            rlast_srv_q <= 1'b1;
`endif
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            wsel_q   <= wsel_d;
            rsel_q   <= rsel_d;
            wgrant_q <= wgrant_d;
            rgrant_q <= rgrant_d;
`ifndef DDR_AXI_ARB_FIXED_PRI_EN
            wlast_srv_q <= wlast_srv_d;
            rlast_srv_q <= rlast_srv_d;
`endif
        end
    end

    assign wgrant = wgrant_q;
    assign rgrant = rgrant_q;

    // Slave-side muxes: each channel is only driven in the state that owns it.
    always_comb begin
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_awlen   = '0;
        s_wvalid  = 1'b0;
        s_wlast   = 1'b0;
        s_wdata   = '0;
        s_bready  = 1'b0;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_rready  = 1'b0;
        if (wstate_q == W_ADDR) begin
            s_awvalid = m_awvalid[wsel_q];
            s_awaddr  = m_awaddr[wsel_q];
            s_awlen   = m_awlen[wsel_q];
        end
        if (wstate_q == W_DATA) begin
            s_wvalid = m_wvalid[wsel_q];
            s_wlast  = m_wlast[wsel_q];
            s_wdata  = m_wdata[wsel_q];
        end
        if (wstate_q == W_RESP) s_bready = m_bready[wsel_q];
        if (rstate_q == R_ADDR) begin
            s_arvalid = m_arvalid[rsel_q];
            s_araddr  = m_araddr[rsel_q];
            s_arlen   = m_arlen[rsel_q];
        end
        if (rstate_q == R_DATA) s_rready = m_rready[rsel_q];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        localparam logic IDX = 1'(gi);
        logic wown, rown;
        assign wown = (wsel_q == IDX);
        assign rown = (rsel_q == IDX) && (rstate_q == R_DATA);
        assign m_awready[gi] = (wstate_q == W_ADDR) && wown && s_awready;
        assign m_wready[gi]  = (wstate_q == W_DATA) && wown && s_wready;
        assign m_bvalid[gi]  = (wstate_q == W_RESP) && wown && s_bvalid;
        assign m_arready[gi] = (rstate_q == R_ADDR) && (rsel_q == IDX) && s_arready;
        assign m_rvalid[gi]  = rown && s_rvalid;
        assign m_rlast[gi]   = rown && s_rlast;
        assign m_rdata[gi]   = rown ? s_rdata : '0;
    end
endmodule

// File: doc/ddr_axi_arbiter.md
# ddr_axi_arbiter

Two-master to one-slave AXI arbiter in front of the DDR controller's AXI slave port. It lets the MBIST master and a user master share the controller. Write and read paths are arbitrated independently. Each grant is held for one complete transaction: write is AW→W burst→B, read is AR→R burst up to rlast. Only the AXI subset used by the controller is carried: no id, size, burst, strb or resp.

## Interface
- AW: BA_BITS+ROW_BITS+COL_BITS+DQ_LEVEL-1, byte address width from the DDR config macros.
- DW: 8<<DQ_LEVEL, data width.
- core_clk  in  1  sole clock, rising edge.
- core_rst_sync  in  1  reset; **synchronous, active-high**.
- mN_awvalid/mN_awready/mN_awaddr[AW-1:0]/mN_awlen[7:0]  in/out/in/in  master N write address, N∈{0,1}.
- mN_wvalid/mN_wready/mN_wlast/mN_wdata[DW-1:0]  in/out/in/in  master N write data.
- mN_bvalid/mN_bready  out/in  master N write response.
- mN_arvalid/mN_arready/mN_araddr[AW-1:0]/mN_arlen[7:0]  in/out/in/in  master N read address.
- mN_rvalid/mN_rready/mN_rlast/mN_rdata[DW-1:0]  out/in/out/out  master N read data.
- s_aw*, s_w*, s_b*, s_ar*, s_r*  mirror of one master port, with directions reversed, toward the DDR controller.
- wgrant[1:0], rgrant[1:0]  out  one-hot current owner; 0 when idle. Debug only.

## Operation
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
  - W_IDLE: if any mN_awvalid is high, latch the winner into wsel. Go to W_ADDR.
  - W_ADDR: route the selected AW to s_aw*. On s_awvalid&s_awready, go to W_DATA.
  - W_DATA: route the selected W. On a beat with wlast, go to W_RESP.
  - W_RESP: route s_bvalid to the selected master. On s_bvalid&mN_bready, go to W_IDLE.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE/R_ADDR behave like the write side.
  - R_DATA: route R. On s_rvalid&mN_rready&s_rlast, go to R_IDLE.
- Arbitration (default): round-robin.
  - The last-served master has lowest priority.
  - The write pointer wlast_srv and read pointer rlast_srv update only when their FSM returns to IDLE.
  - Tie on the first request after reset: master 0 wins.
- Gating: a master that is not granted sees all of its ready/valid outputs held at 0. Payload outputs to the non-granted master (rdata, rlast) are don't-care but driven to 0.
- s_* outputs are 0 in IDLE states.
- No buffering: all data and handshake signals are combinational muxes on registered wsel/rsel.
- Beats are not counted. Burst end is determined solely by wlast/rlast.
- Write and read may be owned by different masters simultaneously.
- A request withdrawn before grant (valid dropped while IDLE) is legal and simply not granted. valid dropping after grant is an AXI violation and its behaviour is unspecified.

## Timing
- Reset state: both FSMs in IDLE, wsel=rsel=0, both last-served pointers=1, and every valid/ready/grant output 0.
- Reset asserted mid-burst: everything returns to reset state on the next edge. The in-flight transaction is abandoned, and the controller is reset with it.
- Arbitration latency: request seen in IDLE at edge k, then s_awvalid/s_arvalid high in cycle k+1. That is one bubble per transaction.
- Back-to-back: IDLE is always visited between transactions, so there is a minimum one idle cycle per channel between transactions.
- Both masters requesting at every IDLE: grants alternate 0,1,0,1 on each side, independently.

## Configuration
- Macro: DDR_AXI_ARB_FIXED_PRI_EN.
- Defined: fixed priority. Master 0 always wins when both request, the last-served pointers are not implemented, and master 1 may starve.
- Undefined (default): round-robin as above.

## Structure
- Shared package/define file holds:
  - FSM state encodings (W_IDLE..W_RESP, R_IDLE..R_DATA).
  - the AW/DW width expressions.
- One sub-module, ddr_axi_rr_pick: a 2-way picker.
  - Inputs: req[1:0], last[0].
  - Output: one-hot gnt.
  - Under DDR_AXI_ARB_FIXED_PRI_EN it reduces to gnt=req[0]?01:req[1]?10:00.
  - It is instantiated once for write and once for read.

## Test plan
- Reset, then only m0 issues a write with awlen=7 and addr 0x0: 8 beats reach s_w with last on beat 8; B is returned to m0 only; m1_* ready/valid outputs stay 0 throughout; wgrant returns to 00 after B.
- m0 and m1 raise awvalid in the same cycle after reset: m0 is served first, then m1; the next simultaneous request goes to m0. The grant sequence is 0,1,0.
- m0 performs a write while m1 performs a read concurrently: both complete with no extra stall, and wgrant=01 and rgrant=10 overlap.
- Read with arlen=3 while slave rvalid toggles every other cycle and m1_rready is held low for 2 cycles: exactly 4 beats are delivered, and rsel is released only after the rlast handshake.
- core_rst_sync is asserted for 1 cycle in the middle of W_DATA beat 3: the next cycle shows all outputs 0, both FSMs in IDLE, and a fresh request is served normally.
- Build with DDR_AXI_ARB_FIXED_PRI_EN and hold both masters continuously requesting for 4 transactions: all 4 go to m0.
